// File: rtl/dpram_arb_if.sv
// Two-port request/grant bus for dpram_arb: port A and port B request lanes plus read return.
interface dpram_arb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata, a_rdata;
  logic [DATA_WIDTH/8-1:0] a_be;
  logic                    b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [DATA_WIDTH-1:0]   b_wdata, b_rdata;
  logic [DATA_WIDTH/8-1:0] b_be;

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/dpram_arb.sv
// Dual-port byte-enable RAM with write arbitration, read-during-write forwarding
// and a per-port read return pipeline of RD_LAT stages.
module dpram_arb_rdpipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [RD_LAT:1]                 vld_pipe;
  logic [RD_LAT:1][DATA_WIDTH-1:0] dat_pipe;

  // Data is zeroed when no read entered, so idle cycles return 0, not stale words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      dat_pipe[1] <= rd_en ? rd_word : '0;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign rvalid = vld_pipe[RD_LAT];
  assign rdata  = dat_pipe[RD_LAT];
endmodule

module dpram_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int ARB_MODE   = 0,
  parameter int WR_FIRST   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dpram_arb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [1:0]                 req, we, gnt, rvalid;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata, rdata;
  logic [1:0][NB-1:0]         be;

  assign req   = {bus.b_req,   bus.a_req};
  assign we    = {bus.b_we,    bus.a_we};
  assign addr  = {bus.b_addr,  bus.a_addr};
  assign wdata = {bus.b_wdata, bus.a_wdata};
  assign be    = {bus.b_be,    bus.a_be};

  assign bus.a_gnt    = gnt[0];
  assign bus.b_gnt    = gnt[1];
  assign bus.a_rvalid = rvalid[0];
  assign bus.b_rvalid = rvalid[1];
  assign bus.a_rdata  = rdata[0];
  assign bus.b_rdata  = rdata[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // last_b records the last conflict winner; reset value means "A won last".
  logic a_wr, b_wr, conflict, b_wins, last_b;
  assign a_wr     = req[0] & we[0];
  assign b_wr     = req[1] & we[1];
  assign conflict = a_wr & b_wr;
  assign b_wins   = (ARB_MODE != 0) && !last_b;
  assign gnt[0]   = req[0] & ~(conflict & b_wins);
  assign gnt[1]   = req[1] & ~(conflict & ~b_wins);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         last_b <= 1'b0;
    else if (conflict && ARB_MODE != 0) last_b <= b_wins;
  end

  logic                  wr_en, wr_sel;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  assign wr_sel  = gnt[1] & we[1];
  assign wr_en   = (gnt[0] & we[0]) | wr_sel;
  assign wr_addr = addr[wr_sel];
  assign wr_data = wdata[wr_sel];
  assign wr_be   = be[wr_sel];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;
    logic                  rd_en, hit;
    logic [DATA_WIDTH-1:0] word;

    assign rd_en = req[p] & ~we[p];
    assign hit   = (WR_FIRST != 0) && gnt[O] && we[O] && (addr[O] == addr[p]);

    // Write-first: merge the opposite port's enabled bytes into the array word.
    always_comb begin
      word = mem[addr[p]];
      if (hit)
        for (int i = 0; i < NB; i++)
          if (be[O][i]) word[i*8 +: 8] = wdata[O][i*8 +: 8];
    end

    dpram_arb_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)) u_rdpipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  (rd_en),
      .rd_word(word),
      .rvalid (rvalid[p]),
      .rdata  (rdata[p])
    );
  end
endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench: u0 = RD_LAT1/fixed/write-first, u1 = RD_LAT2/round-robin/read-first, same stimulus.
module tb_dpram_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dpram_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) i0 ();
  dpram_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) i1 ();

  dpram_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LAT(1), .ARB_MODE(0), .WR_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0));
  dpram_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LAT(2), .ARB_MODE(1), .WR_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    i0.a_req = req; i0.a_we = we; i0.a_addr = addr; i0.a_wdata = wd; i0.a_be = be;
    i1.a_req = req; i1.a_we = we; i1.a_addr = addr; i1.a_wdata = wd; i1.a_be = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    i0.b_req = req; i0.b_we = we; i0.b_addr = addr; i0.b_wdata = wd; i0.b_be = be;
    i1.b_req = req; i1.b_we = we; i1.b_addr = addr; i1.b_wdata = wd; i1.b_be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_u0_a_rvalid", {31'b0, i0.a_rvalid}, 32'd0);
    chk("rst_u0_a_rdata",  i0.a_rdata, 32'h0);
    chk("rst_u1_b_rvalid", {31'b0, i1.b_rvalid}, 32'd0);
    chk("rst_u1_b_rdata",  i1.b_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic write then read, both latencies
    set_a(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    #3;
    chk("wr_u0_a_gnt", {31'b0, i0.a_gnt}, 32'd1);
    chk("wr_u1_a_gnt", {31'b0, i1.a_gnt}, 32'd1);
    tick();
    set_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    #3;
    chk("rd_u0_a_gnt", {31'b0, i0.a_gnt}, 32'd1);
    tick();
    idle();
    chk("lat1_u0_rvalid", {31'b0, i0.a_rvalid}, 32'd1);
    chk("lat1_u0_rdata",  i0.a_rdata, 32'hDEADBEEF);
    chk("lat1_u1_rvalid_early", {31'b0, i1.a_rvalid}, 32'd0);
    tick();
    chk("lat1_u0_idle_rvalid", {31'b0, i0.a_rvalid}, 32'd0);
    chk("lat1_u0_idle_rdata",  i0.a_rdata, 32'h0);
    chk("lat2_u1_rvalid", {31'b0, i1.a_rvalid}, 32'd1);
    chk("lat2_u1_rdata",  i1.a_rdata, 32'hDEADBEEF);

    // Byte enables
    set_a(1'b1, 1'b1, 8'h05, 32'h11223344, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 8'h05, 32'hAABBCCDD, 4'h5);
    tick();
    set_a(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    tick();
    idle();
    chk("be_u0_rdata", i0.a_rdata, 32'h11BB33DD);
    tick();
    chk("be_u1_rdata", i1.a_rdata, 32'h11BB33DD);

    // Write conflicts: fixed priority vs round-robin B, A, B
    set_a(1'b1, 1'b1, 8'h20, 32'hAAAA0000, 4'hF);
    set_b(1'b1, 1'b1, 8'h20, 32'hBBBB0000, 4'hF);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("cf_u0_a_gnt", {31'b0, i0.a_gnt}, 32'd1);
      chk("cf_u0_b_gnt", {31'b0, i0.b_gnt}, 32'd0);
      chk("cf_u1_a_gnt", {31'b0, i1.a_gnt}, (c == 1) ? 32'd1 : 32'd0);
      chk("cf_u1_b_gnt", {31'b0, i1.b_gnt}, (c == 1) ? 32'd0 : 32'd1);
      tick();
    end
    // Lone A write must not move the pointer: next conflict still goes to A
    set_b(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #3;
    chk("lone_u1_a_gnt", {31'b0, i1.a_gnt}, 32'd1);
    tick();
    set_b(1'b1, 1'b1, 8'h20, 32'hBBBB0000, 4'hF);
    #3;
    chk("rr_after_lone_u1_a_gnt", {31'b0, i1.a_gnt}, 32'd1);
    chk("rr_after_lone_u1_b_gnt", {31'b0, i1.b_gnt}, 32'd0);
    tick();
    idle();

    // Read during write, same address
    set_a(1'b1, 1'b1, 8'h30, 32'h0, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 8'h30, 32'h12345678, 4'hF);
    set_b(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
    #3;
    chk("rdw_u0_b_gnt", {31'b0, i0.b_gnt}, 32'd1);
    tick();
    idle();
    chk("rdw_u0_wrfirst", i0.b_rdata, 32'h12345678);
    tick();
    chk("rdw_u1_rdfirst", i1.b_rdata, 32'h00000000);
    set_a(1'b1, 1'b1, 8'h30, 32'hFFFFFFFF, 4'h3);
    set_b(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
    tick();
    idle();
    chk("rdw_u0_merge", i0.b_rdata, 32'h1234FFFF);
    tick();
    chk("rdw_u1_old", i1.b_rdata, 32'h12345678);
    set_a(1'b1, 1'b1, 8'h31, 32'h55555555, 4'hF);
    set_b(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
    tick();
    idle();
    chk("rdw_u0_diff_addr", i0.b_rdata, 32'h1234FFFF);
    tick();
    chk("rdw_u1_diff_addr", i1.b_rdata, 32'h1234FFFF);

    // Both ports streaming reads of 0x00 and 0xFF
    set_a(1'b1, 1'b1, 8'h00, 32'hCAFE0000, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 8'hFF, 32'h0BADF00D, 4'hF);
    tick();
    set_a(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("str_u0_a_rvalid", {31'b0, i0.a_rvalid}, 32'd1);
      chk("str_u0_a_rdata",  i0.a_rdata, 32'hCAFE0000);
      chk("str_u0_b_rvalid", {31'b0, i0.b_rvalid}, 32'd1);
      chk("str_u0_b_rdata",  i0.b_rdata, 32'h0BADF00D);
      if (i > 0) begin
        chk("str_u1_a_rdata", i1.a_rdata, 32'hCAFE0000);
        chk("str_u1_b_rdata", i1.b_rdata, 32'h0BADF00D);
        chk("str_u1_b_rvalid", {31'b0, i1.b_rvalid}, 32'd1);
      end
    end
    idle();
    tick();
    chk("str_u0_end_rvalid", {31'b0, i0.a_rvalid}, 32'd0);
    chk("str_u1_tail_rdata", i1.b_rdata, 32'h0BADF00D);

    // Reset one cycle after a read grant drops the read
    set_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_u1_rvalid", {31'b0, i1.a_rvalid}, 32'd0);
    tick();
    chk("mid_rst_u1_rvalid_ret", {31'b0, i1.a_rvalid}, 32'd0);
    chk("mid_rst_u1_rdata_ret",  i1.a_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    set_a(1'b1, 1'b1, 8'h20, 32'hAAAA0000, 4'hF);
    set_b(1'b1, 1'b1, 8'h20, 32'hBBBB0000, 4'hF);
    #3;
    chk("rst_ptr_u1_b_gnt", {31'b0, i1.b_gnt}, 32'd1);
    chk("rst_ptr_u1_a_gnt", {31'b0, i1.a_gnt}, 32'd0);
    tick();
    set_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    tick();
    idle();
    chk("keep_u0_a_rdata", i0.a_rdata, 32'hDEADBEEF);
    chk("keep_u0_b_rdata", i0.b_rdata, 32'h11BB33DD);
    tick();
    chk("keep_u1_a_rdata", i1.a_rdata, 32'hDEADBEEF);
    chk("keep_u1_b_rdata", i1.b_rdata, 32'h11BB33DD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpram_arb.md
Name: dpram_arb

Overview:
- Parametrised dual-port RAM used for buffering parsed fields between the parser stages; successor to the fixed-width two-port RAM.
- Adds:
  - req/gnt handshakes per port
  - byte-enable writes
  - write-write arbitration (fixed or round-robin)
  - defined read-during-write policy
  - configurable read latency with rvalid tagging
- Both ports share one clock. Each port may read every cycle; at most one write commits per cycle.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- RD_LAT, 1, read latency in cycles from grant to rvalid; legal values 1 or 2.
- ARB_MODE, 0, write arbitration: 0 = port A fixed priority, 1 = round-robin.
- WR_FIRST, 1, same-address read-during-write: 1 = read returns new data, 0 = read returns old data.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request.
- a_we  input  1  port A write (1) / read (0); qualified by a_req.
- a_addr  input  ADDR_WIDTH  port A address.
- a_wdata  input  DATA_WIDTH  port A write data.
- a_be  input  DATA_WIDTH/8  port A byte enables; bit i covers byte i.
- a_gnt  output  1  port A request accepted this cycle (combinational).
- a_rvalid  output  1  a_rdata valid.
- a_rdata  output  DATA_WIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_be, b_gnt, b_rvalid, b_rdata: same as port A, for port B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - Read pipeline cleared; round-robin pointer points to port A.
  - Memory contents are not reset.
  - Reset asserted mid-read drops the read: no rvalid is produced after reset.
- Reads:
  - A read request (req=1, we=0) is always granted the same cycle.
  - Data is sampled at the grant edge.
  - RD_LAT=1: rvalid=1 and rdata valid on the cycle after grant.
  - RD_LAT=2: one extra output register stage; rvalid after two cycles.
- Idle:
  - When no read was granted, rvalid=0 and rdata is driven to 0, never X/stale.
- Writes:
  - On the granted clock edge, mem[addr] byte i is updated only where be[i]=1.
  - be=0 is a legal no-op write; it is still granted and consumes arbitration.
- Write arbitration, when a_req&a_we and b_req&b_we are both high:
  - ARB_MODE=0: A granted, B gnt=0.
  - ARB_MODE=1: grant the port opposite to the last write winner. The pointer updates only on cycles with a write conflict.
  - A lone write is always granted and does not move the pointer.
  - The losing port must hold req/we/addr/wdata/be stable until gnt=1. The block does not queue requests.
- Read during write, same address, opposite ports, same cycle:
  - WR_FIRST=1: the read returns the merged word (new bytes where be=1, old bytes elsewhere).
  - WR_FIRST=0: the read returns the pre-write word.
  - A read to a different address is unaffected.
- Same port: read and write in the same cycle is impossible (single we per port).
- Address wrap: addresses are used modulo depth; no out-of-range state exists.
- Outputs gnt are combinational from req/we and the arbitration state. rvalid and rdata are registered.

Test Plan:
- Reset, then A writes 0xDEADBEEF to addr 0x10 with be=0xF; A reads 0x10 with RD_LAT=1 -> a_gnt=1 both cycles, a_rvalid=1 one cycle after the read grant, a_rdata=0xDEADBEEF. Repeat with RD_LAT=2 -> data arrives 2 cycles after grant.
- Byte enables: write 0x11223344 to 0x05, then write 0xAABBCCDD with be=0x5 -> a read of 0x05 returns 0x11BB33DD.
- Write conflict, ARB_MODE=0: A and B both write 0x20 for 3 cycles -> a_gnt=1, b_gnt=0 every cycle. With ARB_MODE=1, gnt alternates B, A, B (pointer starts at A after reset).
- Read-during-write: mem[0x30]=0x0; A writes 0x12345678 to 0x30 while B reads 0x30 -> b_rdata=0x12345678 (WR_FIRST=1) or 0x00000000 (WR_FIRST=0).
- Both ports read different addresses 0x00 and 0xFF every cycle for 8 cycles -> both rvalid high continuously with the correct data; address 0xFF (top of depth) accessible.
- Assert rst_n low one cycle after a read grant with RD_LAT=2 -> rvalid stays 0 and rdata=0 through the expected return cycle; memory contents are retained after reset.
